// File: rtl/acquisition_scheduler.sv
// Frame acquisition scheduler: arms the datapath, fires periodic frame triggers, counts completed frames, flags overrun/timeout.
// Latency: outputs are registered; a trigger follows end-of-frame by one cycle at the earliest.
// Backpressure: end-of-frame counts only on a tvalid&tready&tlast beat, so a stalled tlast just holds the block in COLLECT.
module acquisition_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 4000000,
  parameter int unsigned PERIOD_MIN     = 2
) (
  input  logic        master_clock,
  input  logic        resetn,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic        cfg_raw_mode,
  input  logic [31:0] cfg_period,
  input  logic [15:0] cfg_burst_len,
  input  logic        frame_tvalid,
  input  logic        frame_tready,
  input  logic        frame_tlast,
  output logic        acq_enable,
  output logic        send_raw_data,
  output logic        frame_trigger,
  output logic        busy,
  output logic        done,
  output logic [15:0] frames_done,
  output logic        overrun,
  output logic        timeout,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ARM         = 3'd1,
    TRIGGER     = 3'd2,
    COLLECT     = 3'd3,
    WAIT_PERIOD = 3'd4,
    DONE        = 3'd5,
    ERROR       = 3'd6
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] period, period_cnt, watchdog;
  logic [15:0] burst_len, frames_inc;
  logic        stop_pending, eof, period_near, wd_hit, burst_end;

  // period_cnt reads 0 in the cycle exactly `period` cycles after the trigger,
  // so a trigger is scheduled one cycle ahead, while the counter still reads 1.
  always_comb begin
    eof         = frame_tvalid & frame_tready & frame_tlast & (state == COLLECT);
    frames_inc  = (frames_done == 16'hFFFF) ? frames_done : frames_done + 16'd1;
    period_near = (period_cnt <= 32'd1);
    burst_end   = (burst_len != 16'd0) && (frames_inc == burst_len);
    // watchdog holds (cycles since trigger - 1): ERROR lands TIMEOUT_CYCLES after the pulse
    wd_hit      = (watchdog >= TIMEOUT_CYCLES - 32'd2);
    state_nxt   = state;
    case (state)
      IDLE:        if (cfg_start && !cfg_stop) state_nxt = ARM;
      ARM:         state_nxt = cfg_stop ? DONE : TRIGGER;
      TRIGGER:     state_nxt = cfg_stop ? DONE : COLLECT;
      COLLECT: begin
        if (eof) begin
          if (burst_end || stop_pending || cfg_stop) state_nxt = DONE;
          else if (period_near)                      state_nxt = TRIGGER;
          else                                       state_nxt = WAIT_PERIOD;
        end else if (wd_hit) begin
          state_nxt = ERROR;
        end
      end
      WAIT_PERIOD: begin
        if (cfg_stop)         state_nxt = DONE;
        else if (period_near) state_nxt = TRIGGER;
      end
      DONE:        state_nxt = IDLE;
      ERROR: begin
        if (cfg_stop)       state_nxt = IDLE;
        else if (cfg_start) state_nxt = ARM;
      end
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      dbg_state     <= 3'd0;
      acq_enable    <= 1'b0;
      busy          <= 1'b0;
      frame_trigger <= 1'b0;
      done          <= 1'b0;
      send_raw_data <= 1'b0;
      period        <= 32'd0;
      period_cnt    <= 32'd0;
      watchdog      <= 32'd0;
      burst_len     <= 16'd0;
      frames_done   <= 16'd0;
      overrun       <= 1'b0;
      timeout       <= 1'b0;
      stop_pending  <= 1'b0;
    end else begin
      state         <= state_nxt;
      dbg_state     <= state_nxt;
      acq_enable    <= (state_nxt == ARM) || (state_nxt == TRIGGER) ||
                       (state_nxt == COLLECT) || (state_nxt == WAIT_PERIOD);
      busy          <= (state_nxt != IDLE);
      frame_trigger <= (state_nxt == TRIGGER);
      done          <= (state_nxt == DONE);

      if (state == TRIGGER)        period_cnt <= period - 32'd1;
      else if (period_cnt != 32'd0) period_cnt <= period_cnt - 32'd1;

      if (state == TRIGGER)      watchdog <= 32'd0;
      else if (state == COLLECT) watchdog <= watchdog + 32'd1;

      // ARM is only ever entered from IDLE or ERROR: configuration snapshot and result clear
      if (state_nxt == ARM) begin
        period        <= (cfg_period < PERIOD_MIN) ? PERIOD_MIN : cfg_period;
        burst_len     <= cfg_burst_len;
        send_raw_data <= cfg_raw_mode;
        frames_done   <= 16'd0;
        overrun       <= 1'b0;
        timeout       <= 1'b0;
        stop_pending  <= 1'b0;
      end else begin
        if (eof) frames_done <= frames_inc;
        if (eof && state_nxt == TRIGGER && period_cnt == 32'd0) overrun <= 1'b1;
        if (state == COLLECT && state_nxt == ERROR) timeout <= 1'b1;
        if (state == DONE)                      stop_pending <= 1'b0;
        else if (state == COLLECT && cfg_stop)  stop_pending <= 1'b1;
      end
    end
  end

endmodule
